// File: rtl/ysyx_22040088_ifu_pkg.sv
// Shared definitions for the ysyx_22040088 instruction fetch unit:
// default reset PC, NOP encoding and FSM state encodings.
package ysyx_22040088_ifu_pkg;

   localparam int unsigned XLEN_DEF   = 64;
   localparam int unsigned INST_W     = 32;
   localparam int unsigned PERF_W     = 64;
   localparam logic [63:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;
   localparam logic [31:0] NOP_INST     = 32'h0000_0013;

   typedef enum logic [1:0] {
      IFU_IDLE = 2'd0,
      IFU_REQ  = 2'd1,
      IFU_WAIT = 2'd2,
      IFU_HOLD = 2'd3
   } ifu_state_e;

endpackage

// File: rtl/ysyx_22040088_pc_reg.sv
// Architectural fetch PC: reset value, redirect mux (word-aligned) and +4 step.
// pc_nxt_c exposes the value the PC takes on the coming edge.
module ysyx_22040088_pc_reg
   import ysyx_22040088_ifu_pkg::*;
#(
   parameter int unsigned         XLEN     = XLEN_DEF,
   parameter logic [XLEN-1:0]     RESET_PC = XLEN'(RESET_PC_DEF)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            inc,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_nxt_c
);

   // Redirect has priority; increment wraps modulo 2^XLEN.
   always_comb begin
      pc_nxt_c = pc;
      if (redirect_valid) begin
         pc_nxt_c = redirect_pc & ~XLEN'(3);
      end else if (inc) begin
         pc_nxt_c = pc + XLEN'(4);
      end
   end

   // PC state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc <= RESET_PC;
      end else begin
         pc <= pc_nxt_c;
      end
   end

endmodule

// File: rtl/ysyx_22040088_ifu.sv
// Instruction fetch unit: single-outstanding word fetch, holding register
// toward the decoder, and redirect handling with wrong-path drop.
// Optional perf counters enabled by defining YSYX_22040088_IFU_PERF_EN.
module ysyx_22040088_ifu
   import ysyx_22040088_ifu_pkg::*;
#(
   parameter int unsigned     XLEN     = XLEN_DEF,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              redirect_valid,
   input  logic [XLEN-1:0]   redirect_pc,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [XLEN-1:0]   imem_req_addr,
   input  logic              imem_resp_valid,
   input  logic [INST_W-1:0] imem_resp_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [INST_W-1:0] out_inst,
   output logic [XLEN-1:0]   out_pc
`ifdef YSYX_22040088_IFU_PERF_EN
   ,
   output logic [PERF_W-1:0] perf_fetch_cnt,
   output logic [PERF_W-1:0] perf_stall_cnt,
   output logic [PERF_W-1:0] perf_flush_cnt
`endif
);

   ifu_state_e          state_q, state_d;
   logic                drop_q, drop_d;
   logic                load_req, latch_out, handshake, hold_valid;
   logic [XLEN-1:0]     pc, pc_nxt_c, req_addr_q, pc_out_q;
   logic [INST_W-1:0]   inst_q;

   ysyx_22040088_pc_reg #(
      .XLEN     (XLEN),
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inc            (handshake),
      .pc             (pc),
      .pc_nxt_c       (pc_nxt_c)
   );

   assign hold_valid     = (state_q == IFU_HOLD);
   assign out_valid      = hold_valid & ~redirect_valid;
   assign handshake      = out_valid & out_ready;
   assign imem_req_valid = (state_q == IFU_REQ);
   assign imem_req_addr  = req_addr_q;
   assign out_inst       = inst_q;
   assign out_pc         = pc_out_q;

   // Next state, drop flag and register-load strobes.
   always_comb begin
      state_d   = state_q;
      drop_d    = drop_q;
      load_req  = 1'b0;
      latch_out = 1'b0;
      case (state_q)
         IFU_IDLE: begin
            state_d  = IFU_REQ;
            load_req = 1'b1;
         end
         IFU_REQ: begin
            if (redirect_valid) drop_d = 1'b1;
            if (imem_req_ready) state_d = IFU_WAIT;
         end
         IFU_WAIT: begin
            if (imem_resp_valid) begin
               if (drop_q || redirect_valid) begin
                  drop_d   = 1'b0;
                  state_d  = IFU_REQ;
                  load_req = 1'b1;
               end else begin
                  latch_out = 1'b1;
                  state_d   = IFU_HOLD;
               end
            end else if (redirect_valid) begin
               drop_d = 1'b1;
            end
         end
         IFU_HOLD: begin
            if (redirect_valid || handshake) begin
               state_d  = IFU_REQ;
               load_req = 1'b1;
            end
         end
         default: state_d = IFU_IDLE;
      endcase
   end

   // FSM state and wrong-path drop flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IFU_IDLE;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         drop_q  <= drop_d;
      end
   end

   // Request address is captured on entry to REQ so it stays stable until accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_addr_q <= RESET_PC;
      end else if (load_req) begin
         req_addr_q <= pc_nxt_c;
      end
   end

   // Holding register presented to the decoder.
   always_ff @(posedge clk) begin
      if (rst) begin
         inst_q   <= NOP_INST;
         pc_out_q <= RESET_PC;
      end else if (latch_out) begin
         inst_q   <= imem_resp_data;
         pc_out_q <= pc;
      end
   end

`ifdef YSYX_22040088_IFU_PERF_EN
   // Handshake, stall and flush counters; all wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetch_cnt <= '0;
         perf_stall_cnt <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if (handshake) perf_fetch_cnt <= perf_fetch_cnt + PERF_W'(1);
         if ((state_q == IFU_REQ) || (state_q == IFU_WAIT))
            perf_stall_cnt <= perf_stall_cnt + PERF_W'(1);
         if (redirect_valid && (state_q != IFU_IDLE))
            perf_flush_cnt <= perf_flush_cnt + PERF_W'(1);
      end
   end
`else
   // Performance counters not built.
`endif

endmodule

// File: tb/tb_ysyx_22040088_ifu.sv
// Self-checking bench for ysyx_22040088_ifu: directed scenarios followed by
// randomized traffic, checked against an architectural fetch-stream model.
module tb_ysyx_22040088_ifu;

   localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

   logic        clk, rst, redirect_valid;
   logic [63:0] redirect_pc;
   logic        imem_req_valid, imem_req_ready;
   logic [63:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        out_valid, out_ready;
   logic [31:0] out_inst;
   logic [63:0] out_pc;

   ysyx_22040088_ifu dut (
      .clk             (clk),
      .rst             (rst),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_inst        (out_inst),
      .out_pc          (out_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_vec = 0, n_err = 0, cyc = 0;
   logic [63:0] exp_pc = RESET_PC;
   bit          rand_mode = 0, resp_override = 0;
   int          resp_delay = 1;
   bit          pend = 0;
   int          pend_cnt = 0;
   logic [63:0] pend_addr = '0;
   bit          last_acc, last_ov, last_rv;
   bit          req_prev = 0, prev_req_wait = 0, prev_hold = 0;
   logic [63:0] prev_addr, prev_opc;
   logic [31:0] prev_inst;
   logic [63:0] hs_pc_q[$];
   logic [31:0] hs_inst_q[$];
   int          hs_cyc_q[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Memory contents seen by the fetch unit.
   function automatic logic [31:0] mem_fn(input logic [63:0] a);
      if (a == 64'h8000_0000) return 32'h0010_0093;
      if (a == 64'h8000_0004) return 32'h0020_0113;
      return a[31:0] ^ a[63:32] ^ 32'h6b8b_4567;
   endfunction

   // One clock: observe and check at negedge, then drive memory/random inputs after posedge.
   task automatic tick();
      bit          acc;
      logic [63:0] acc_addr;
      @(negedge clk);
      cyc++;
      last_ov  = out_valid;
      last_rv  = imem_req_valid;
      acc      = imem_req_valid && imem_req_ready && !rst;
      acc_addr = imem_req_addr;
      last_acc = acc;
      if (rst) begin
         exp_pc        = RESET_PC;
         req_prev      = 0;
         prev_req_wait = 0;
         prev_hold     = 0;
      end else begin
         if (imem_req_valid && !req_prev) chk("req_addr", imem_req_addr, exp_pc);
         if (prev_req_wait) begin
            chk("req_stable_v", imem_req_valid, 1);
            chk("req_stable_a", imem_req_addr, prev_addr);
         end
         if (prev_hold) begin
            chk("out_stable_pc", out_pc, prev_opc);
            chk("out_stable_inst", out_inst, prev_inst);
         end
         if (redirect_valid) chk("redirect_gate", out_valid, 0);
         if (out_valid && out_ready) begin
            chk("out_pc", out_pc, exp_pc);
            chk("out_inst", out_inst, mem_fn(exp_pc));
            hs_pc_q.push_back(out_pc);
            hs_inst_q.push_back(out_inst);
            hs_cyc_q.push_back(cyc);
            exp_pc = exp_pc + 64'd4;
         end
         if (redirect_valid) exp_pc = redirect_pc & ~64'd3;
         req_prev      = imem_req_valid;
         prev_req_wait = imem_req_valid && !imem_req_ready;
         prev_addr     = imem_req_addr;
         prev_hold     = out_valid && !out_ready;
         prev_opc      = out_pc;
         prev_inst     = out_inst;
      end
      @(posedge clk);
      #1;
      imem_resp_valid = 1'b0;
      if (acc) begin
         pend      = 1;
         pend_cnt  = resp_delay;
         pend_addr = acc_addr;
      end
      if (pend) begin
         pend_cnt--;
         if (pend_cnt == 0) begin
            pend            = 0;
            imem_resp_valid = 1'b1;
            imem_resp_data  = resp_override ? 32'hDEAD_BEEF : mem_fn(pend_addr);
            resp_override   = 0;
         end
      end
      if (rand_mode) begin
         imem_req_ready = ($urandom % 4) != 0;
         out_ready      = ($urandom % 3) != 0;
         redirect_valid = ($urandom % 12) == 0;
         if (($urandom % 4) == 0) redirect_pc = {60'hFFF_FFFF_FFFF_FFFF, 4'($urandom)};
         else                     redirect_pc = {$urandom, $urandom};
         resp_delay = 1 + int'($urandom % 3);
      end
   endtask

   // kind: 0 handshake, 1 request accepted, 2 out_valid seen, 3 request valid seen
   task automatic run_until(input int kind, input int max_cyc, input string tag);
      bit hit = 0;
      int n0  = hs_pc_q.size();
      for (int i = 0; i < max_cyc && !hit; i++) begin
         tick();
         case (kind)
            0: hit = hs_pc_q.size() > n0;
            1: hit = last_acc;
            2: hit = last_ov;
            default: hit = last_rv;
         endcase
      end
      chk({tag, "_reached"}, 64'(hit), 1);
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_req_valid"}, imem_req_valid, 0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_out_inst"}, out_inst, 32'h0000_0013);
      chk({tag, "_out_pc"}, out_pc, RESET_PC);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [63:0] old_addr;
      int          n0;
      rst = 1; redirect_valid = 0; redirect_pc = '0;
      imem_req_ready = 1; imem_resp_valid = 0; imem_resp_data = '0; out_ready = 1;
      repeat (3) tick();
      reset_checks("rst0");

      // Two fetches, memory always ready, 1-cycle responses
      rst = 0;
      run_until(0, 20, "t1_hs0");
      run_until(0, 20, "t1_hs1");
      chk("t1_pc0", hs_pc_q[0], 64'h8000_0000);
      chk("t1_inst0", hs_inst_q[0], 32'h0010_0093);
      chk("t1_pc1", hs_pc_q[1], 64'h8000_0004);
      chk("t1_inst1", hs_inst_q[1], 32'h0020_0113);
      chk("t1_spacing", 64'(hs_cyc_q[1] - hs_cyc_q[0]), 3);

      // Decoder backpressure for 5 cycles
      out_ready = 0;
      run_until(2, 20, "t2_valid");
      repeat (5) begin
         tick();
         chk("t2_ov_held", last_ov, 1);
         chk("t2_no_req", last_rv, 0);
      end
      out_ready = 1;
      n0 = hs_pc_q.size();
      run_until(0, 5, "t2_hs");
      chk("t2_hs_pc", hs_pc_q[n0], 64'h8000_0008);

      // Redirect in WAIT; the stale response must be dropped
      resp_delay = 2;
      run_until(1, 20, "t3_acc");
      resp_override  = 1;
      redirect_valid = 1; redirect_pc = 64'h8000_1002;
      tick();
      redirect_valid = 0;
      n0 = hs_pc_q.size();
      run_until(0, 20, "t3_hs");
      chk("t3_hs_pc", hs_pc_q[n0], 64'h8000_1000);

      // Redirect in REQ while memory is not ready
      resp_delay = 1;
      imem_req_ready = 0;
      run_until(3, 20, "t4_req");
      old_addr = imem_req_addr;
      redirect_valid = 1; redirect_pc = 64'h8000_2000;
      tick();
      redirect_valid = 0;
      tick();
      tick();
      chk("t4_addr_held", imem_req_addr, old_addr);
      imem_req_ready = 1;
      n0 = hs_pc_q.size();
      run_until(0, 20, "t4_hs");
      chk("t4_hs_pc", hs_pc_q[n0], 64'h8000_2000);

      // Redirect in HOLD with out_ready the same cycle
      out_ready = 0;
      run_until(2, 20, "t5_valid");
      redirect_valid = 1; redirect_pc = 64'h8000_3000; out_ready = 1;
      n0 = hs_pc_q.size();
      tick();
      chk("t5_no_xfer", 64'(hs_pc_q.size()), 64'(n0));
      redirect_valid = 0;
      run_until(0, 20, "t5_hs");
      chk("t5_hs_pc", hs_pc_q[n0], 64'h8000_3000);

      // PC wrap at the top of the address space
      redirect_valid = 1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
      tick();
      redirect_valid = 0;
      n0 = hs_pc_q.size();
      run_until(0, 20, "t7_hs0");
      run_until(0, 20, "t7_hs1");
      chk("t7_pc_top", hs_pc_q[n0], 64'hFFFF_FFFF_FFFF_FFFC);
      chk("t7_pc_wrap", hs_pc_q[n0+1], 64'h0);

      // Reset during WAIT; response lands inside reset, spurious one right after
      resp_delay = 3;
      run_until(1, 20, "t6_acc");
      rst = 1;
      repeat (4) tick();
      reset_checks("t6_rst");
      rst = 0;
      imem_resp_valid = 1; imem_resp_data = 32'hDEAD_BEEF;
      n0 = hs_pc_q.size();
      run_until(0, 20, "t6_hs");
      chk("t6_hs_pc", hs_pc_q[n0], RESET_PC);

      // Randomized traffic
      n0 = hs_pc_q.size();
      rand_mode = 1;
      repeat (3000) tick();
      rand_mode = 0;
      redirect_valid = 0;
      chk("rand_progress", 64'(hs_pc_q.size() - n0 > 100), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ysyx_22040088_ifu.md
Name: ysyx_22040088_ifu

Overview:
Instruction fetch stage for the RV64 NPC core, sitting directly upstream of the control unit (decoder). It owns the architectural fetch PC and issues word fetches over a valid/ready request channel plus a valid-only response channel. It presents {inst, pc} to the decoder through a valid/ready handshake. It accepts redirects for branches, jumps, traps and mret from the execute/commit side, and discards any wrong-path fetch that is already in flight.

Parameters:
RESET_PC, 64'h0000_0000_8000_0000, PC loaded on reset.
XLEN, 64, PC/address width.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
redirect_valid  in  1  redirect fetch this cycle.
redirect_pc  in  XLEN  redirect target; bits [1:0] ignored (forced 0).
imem_req_valid  out  1  fetch request valid.
imem_req_ready  in  1  memory accepts request.
imem_req_addr  out  XLEN  fetch address, word-aligned.
imem_resp_valid  in  1  response valid, one-cycle pulse.
imem_resp_data  in  32  fetched instruction word.
out_valid  out  1  instruction valid to decoder.
out_ready  in  1  decoder accepts.
out_inst  out  32  instruction word.
out_pc  out  XLEN  PC of out_inst.

Behaviour:
- Reset values: state=IDLE, pc=RESET_PC, drop=0, imem_req_valid=0, out_valid=0, out_inst=32'h0000_0013 (nop), out_pc=RESET_PC. Reset applied in any state aborts all activity. Any response arriving in the first cycle after reset is ignored.
- States:
  - IDLE: exactly one cycle after reset deasserts, then REQ.
  - REQ: imem_req_valid=1, imem_req_addr=pc. On imem_req_ready, go to WAIT.
  - WAIT: await imem_resp_valid. If drop=0, latch resp into out_inst and pc into out_pc, then go to HOLD. If drop=1, clear drop and go to REQ.
  - HOLD: out_valid=hold_valid & ~redirect_valid. On out_valid&out_ready: pc<=pc+4, go to REQ.
- Request stability: once imem_req_valid=1, imem_req_addr and valid stay constant until accepted.
- Response timing: imem_resp_valid is legal only in WAIT, at earliest one cycle after acceptance. A response in any other state is ignored.
- Throughput: at least 3 cycles per instruction (REQ, WAIT, HOLD); no overlap.
- Redirect, all states: pc<=redirect_pc&~3 on the same edge.
  - REQ, not yet accepted: request is completed unchanged, drop<=1.
  - REQ, accepted the same cycle: drop<=1, go to WAIT.
  - WAIT without response: drop<=1.
  - WAIT with response the same cycle: response discarded, go to REQ.
  - HOLD: held instruction discarded, out_valid forced 0 that cycle, go to REQ.
  - IDLE: pc updated, proceed as normal.
- Redirect and out_ready in the same cycle: no transfer (out_valid gated low); the redirect wins.
- Back-to-back redirects: the last one wins; drop is a single bit because at most one request is outstanding.
- PC arithmetic wraps modulo 2^XLEN; pc+4 at all-ones wraps to 0.
- out_inst/out_pc stay stable while out_valid=1 and out_ready=0.

Optional Feature:
Macro YSYX_22040088_IFU_PERF_EN.
- Defined: adds output ports perf_fetch_cnt (64, counts out_valid&out_ready handshakes), perf_stall_cnt (64, counts cycles in REQ/WAIT) and perf_flush_cnt (64, counts redirects that hit a non-IDLE state). All three reset to 0 and wrap.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/header ysyx_22040088_defs: RESET_PC default, NOP encoding 32'h0000_0013, state encodings IFU_IDLE/REQ/WAIT/HOLD (2-bit).
- One natural sub-module: ysyx_22040088_pc_reg (PC register with reset value, redirect mux and +4 increment).
- The FSM and output holding register stay in the top module.

Test Plan:
- Reset release, memory ready immediately, responses 1 cycle later, data 32'h00100093 then 32'h00200113, out_ready=1 → requests at 80000000, 80000004; outputs (80000000, 00100093) then (80000004, 00200113), 3-cycle spacing.
- Backpressure: out_ready=0 for 5 cycles in HOLD → out_valid stays 1; out_inst/out_pc unchanged; no new request issued; pc+4 only after the handshake.
- Redirect to 80001002 while in WAIT, stale response 32'hDEADBEEF arrives next cycle → stale word never appears on out; next request addr = 80001000.
- Redirect in REQ with imem_req_ready=0 for 3 cycles → addr stays at the old pc until accepted; that response is discarded; next request uses the redirect target.
- Redirect in HOLD with out_ready=1 the same cycle → out_valid=0 that cycle; no transfer; next request = redirect target.
- Reset asserted in WAIT, response arrives during reset → outputs return to reset values; first post-reset output is at pc=80000000.
